pipeline_control: RTL

PIPELINE_CONTROL -- requirements
Module: pipeline_control

---
 rtl/pipeline_control_pkg.sv | 15 +
 rtl/pipeline_control_hazard_detect.sv | 31 +++
 rtl/pipeline_control.sv | 113 +++++++++++
 3 files changed

// File: rtl/pipeline_control_pkg.sv
// Shared definitions for the pipeline hazard/branch controller: state
// encoding, the zero-register index and the default register-address width.
package pipeline_control_pkg;

    localparam int REG_W = 5;
    localparam int XZR   = 31;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_ILLEGAL = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_control_hazard_detect.sv
// Load-use / RAW hazard detection against the EX and MEM destinations.
// WB is not compared: the register file writes before it reads.
module hazard_detect
    import pipeline_control_pkg::*;
#(
    parameter int W = 5
) (
    input  logic         id_valid,
    input  logic [W-1:0] id_rn,
    input  logic [W-1:0] id_rm,
    input  logic         ex_regwrite,
    input  logic [W-1:0] ex_rd,
    input  logic         mem_regwrite,
    input  logic [W-1:0] mem_rd,
    output logic         hazard
);

    localparam logic [W-1:0] XZR_ADDR = W'(XZR);

    logic ex_hit;
    logic mem_hit;

    always_comb begin
        ex_hit  = ex_regwrite && (ex_rd != XZR_ADDR)
                  && ((ex_rd == id_rn) || (ex_rd == id_rm));
        mem_hit = mem_regwrite && (mem_rd != XZR_ADDR)
                  && ((mem_rd == id_rn) || (mem_rd == id_rm));
        hazard  = id_valid && (ex_hit || mem_hit);
    end

endmodule

// File: rtl/pipeline_control.sv
// Pipeline stall/flush controller: RUN/STALL/FLUSH FSM with zero-latency
// combinational control outputs and saturating stall/flush counters.
//
// state    | meaning
// ST_RUN   | normal flow
// ST_STALL | bubble inserted last cycle, hazard still being re-evaluated
// ST_FLUSH | one cycle after a taken branch; branch input ignored
module pipeline_control
#(
    parameter int REG_W = pipeline_control_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_branch_taken,
    output logic             pc_write,
    output logic             pr1_write,
    output logic             pr2_bubble,
    output logic             flush,
    output logic             pcsrc_sel,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    import pipeline_control_pkg::*;

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             hazard;
    logic             branch_act;

    hazard_detect #(.W(REG_W)) u_hazard_detect (
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .ex_regwrite  (ex_regwrite),
        .ex_rd        (ex_rd),
        .mem_regwrite (mem_regwrite),
        .mem_rd       (mem_rd),
        .hazard       (hazard)
    );

    // The branch in MEM during FLUSH is the one already taken; ignore it.
    assign branch_act = mem_branch_taken && (state_q != ST_FLUSH);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_RUN;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (branch_act)  state_d = ST_FLUSH;
                else if (hazard) state_d = ST_STALL;
                else             state_d = ST_RUN;
            end
            ST_FLUSH: state_d = hazard ? ST_STALL : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        pc_write   = 1'b1;
        pr1_write  = 1'b1;
        pr2_bubble = 1'b0;
        flush      = 1'b0;
        pcsrc_sel  = 1'b0;
        if (reset) begin
            pc_write  = 1'b0;
            pr1_write = 1'b0;
            flush     = 1'b1;
        end else if (branch_act) begin
            flush     = 1'b1;
            pcsrc_sel = 1'b1;
        end else if (hazard) begin
            pc_write   = 1'b0;
            pr1_write  = 1'b0;
            pr2_bubble = 1'b1;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (pr2_bubble && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + CNT_W'(1);
        if (flush && !reset && (flush_count_q != {CNT_W{1'b1}}))
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    assign ctrl_state  = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule
